// File: rtl/bnn_decrypt_sequencer.sv
// bnn_decrypt_sequencer: buffers cipher bytes in a small FIFO, drives the
// byte-wide decryptor one byte at a time over start/done, and packs the
// plaintext bytes into WORD_BYTES-wide words for the weight loader.
//
// Handshakes:
//   s_valid/s_ready and m_valid/m_ready follow strict valid/ready semantics.
//   A beat transfers on a rising edge where both are high. Once the source
//   raises valid, it holds valid and the payload stable until that edge.
//   The sink may drive ready independently of valid.
//   dec_start/dec_done is a four-phase level handshake:
//   - start rises with the byte and key applied;
//   - done rises with the result valid;
//   - start falls;
//   - done falls before the next start may rise.
module bnn_decrypt_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int WORD_BYTES = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [7:0]              s_data,
  input  logic                    s_last,
  input  logic [7:0]              key_in,
  output logic                    dec_start,
  output logic [7:0]              dec_cipher,
  output logic [7:0]              dec_key,
  input  logic [7:0]              dec_plain,
  input  logic                    dec_done,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [8*WORD_BYTES-1:0] m_data,
  output logic                    m_last,
  output logic                    err,
  output logic [1:0]              dbg_state_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, REL = 2'd2, FLUSH = 2'd3} state_t;

  // Input FIFO storage: {last, data}. The extra pointer bit separates full from empty.
  logic [8:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        full, empty, push, pop;
  logic [8:0]  head;

  state_t                  state_q, state_d;
  logic [IW-1:0]           byte_idx_q, byte_idx_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [8*WORD_BYTES-1:0] pack_q, pack_d;
  logic                    dec_start_q, dec_start_d;
  logic [7:0]              cipher_q, cipher_d;
  logic [7:0]              key_q, key_d;
  logic                    cur_last_q, cur_last_d;
  logic                    m_valid_q, m_valid_d;
  logic [8*WORD_BYTES-1:0] m_data_q, m_data_d;
  logic                    m_last_q, m_last_d;
  logic                    err_q, err_d;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = s_valid && !full;
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // FIFO storage write; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {s_last, s_data};
  end

  // FIFO pointers: write side advances on push, read side on FSM pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Sequencer state, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byte_idx_q  <= '0;
      tmo_q       <= '0;
      pack_q      <= '0;
      dec_start_q <= 1'b0;
      cipher_q    <= '0;
      key_q       <= '0;
      cur_last_q  <= 1'b0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_last_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      tmo_q       <= tmo_d;
      pack_q      <= pack_d;
      dec_start_q <= dec_start_d;
      cipher_q    <= cipher_d;
      key_q       <= key_d;
      cur_last_q  <= cur_last_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_last_q    <= m_last_d;
      err_q       <= err_d;
    end
  end

  // Next-state logic: pop/request, collect result or time out, release, flush word.
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    tmo_d       = tmo_q;
    pack_d      = pack_q;
    dec_start_d = dec_start_q;
    cipher_d    = cipher_q;
    key_d       = key_q;
    cur_last_d  = cur_last_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    err_d       = err_q;
    pop         = 1'b0;

    // An accepted word frees the output register unless FLUSH reloads it below.
    if (m_valid_q && m_ready) m_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          cipher_d    = head[7:0];
          cur_last_d  = head[8];
          key_d       = key_in;
          dec_start_d = 1'b1;
          tmo_d       = '0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (dec_done) begin
          pack_d[{byte_idx_q, 3'b000} +: 8] = dec_plain;
          dec_start_d = 1'b0;
          state_d     = REL;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // A lost byte leaves its lane zero; the frame keeps its length.
          pack_d[{byte_idx_q, 3'b000} +: 8] = 8'h00;
          err_d       = 1'b1;
          dec_start_d = 1'b0;
          state_d     = REL;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      REL: begin
        if (!dec_done) begin
          if (byte_idx_q == IW'(WORD_BYTES - 1) || cur_last_q) begin
            state_d = FLUSH;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = IDLE;
          end
        end
      end
      FLUSH: begin
        if (!m_valid_q || m_ready) begin
          m_data_d   = pack_q;
          m_last_d   = cur_last_q;
          m_valid_d  = 1'b1;
          pack_d     = '0;
          byte_idx_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign s_ready     = !full;
  assign dec_start   = dec_start_q;
  assign dec_cipher  = cipher_q;
  assign dec_key     = key_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_last      = m_last_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bnn_decrypt_sequencer.sv
// Directed bench for bnn_decrypt_sequencer with an XOR decryptor stub.
module tb_bnn_decrypt_sequencer;

  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_REL = 2'd2, S_FLUSH = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        s_last = 1'b0;
  logic [7:0]  key_in = 8'h00;
  logic        dec_start;
  logic [7:0]  dec_cipher, dec_key, dec_plain;
  logic        dec_done = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_last;
  logic        err;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: expected words as {last, data}.
  logic [32:0] exp_q[$];

  bnn_decrypt_sequencer #(.FIFO_DEPTH(4), .WORD_BYTES(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .key_in(key_in),
    .dec_start(dec_start), .dec_cipher(dec_cipher), .dec_key(dec_key),
    .dec_plain(dec_plain), .dec_done(dec_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .err(err), .dbg_state_o(dbg_state)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Decryptor stub: plain = cipher ^ key; done after start sampled high 3 times.
  logic stub_dead = 1'b0;
  int   stub_cnt  = 0;
  assign dec_plain = dec_cipher ^ dec_key;
  always @(posedge clk) begin
    if (!dec_start || stub_dead) begin
      stub_cnt <= 0;
      dec_done <= 1'b0;
    end else if (stub_cnt == 2) begin
      dec_done <= 1'b1;
    end else begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output scoreboard: every accepted word must match the queue head.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {31'd0, m_last, m_data}, 64'h1_0000_0000_DEAD);
      end else begin
        check("word", {31'd0, m_last, m_data}, {31'd0, exp_q[0]});
        void'(exp_q.pop_front());
      end
    end
  end

  // Output hold: a stalled word keeps valid, data and last until taken.
  logic        hold_pend = 1'b0;
  logic [32:0] hold_word;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) check("m_hold", {30'd0, m_valid, m_last, m_data}, {30'd0, 1'b1, hold_word});
      hold_pend = m_valid && !m_ready;
      hold_word = {m_last, m_data};
    end
  end

  // Decryptor handshake: no start while done high; cipher/key frozen through REQ+REL.
  logic       prev_start = 1'b0;
  logic [7:0] cap_cipher, cap_key;
  int         pulse_cnt = 0, last_len = 0, pulses = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_start = 1'b0;
      pulse_cnt  = 0;
    end else begin
      if (dec_start && !prev_start) begin
        check("start_while_done", {63'd0, dec_done}, 64'd0);
        cap_cipher = dec_cipher;
        cap_key    = dec_key;
      end
      if (dbg_state == S_REQ || dbg_state == S_REL)
        check("dec_hold", {48'd0, dec_cipher, dec_key}, {48'd0, cap_cipher, cap_key});
      if (dec_start) pulse_cnt++;
      else if (pulse_cnt != 0) begin
        last_len  = pulse_cnt;
        pulse_cnt = 0;
        pulses++;
      end
      prev_start = dec_start;
    end
  end

  // Driver: present one byte and hold it until accepted (entered after posedge+1).
  task automatic push_byte(input logic [7:0] d, input logic l);
    int guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk);
    while (!s_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) check("push_accept", 64'd0, 64'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check(tag, exp_q.size(), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    int pulses_before;

    // Reset values.
    #2;
    check("rst_s_ready",    s_ready,    1);
    check("rst_dec_start",  dec_start,  0);
    check("rst_dec_cipher", dec_cipher, 0);
    check("rst_dec_key",    dec_key,    0);
    check("rst_m_valid",    m_valid,    0);
    check("rst_m_data",     m_data,     0);
    check("rst_m_last",     m_last,     0);
    check("rst_err",        err,        0);
    check("rst_state",      dbg_state,  S_IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycles(2);

    // Single word, key 0x3C; also push-to-request latency.
    key_in = 8'h3C;
    exp_q.push_back({1'b1, 32'h780F_1E2D});
    push_byte(8'h11, 1'b0);
    check("req_not_yet", dec_start, 0);
    @(posedge clk); #1;
    check("req_start",  dec_start,  1);
    check("req_cipher", dec_cipher, 8'h11);
    check("req_key",    dec_key,    8'h3C);
    check("req_state",  dbg_state,  S_REQ);
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b0);
    push_byte(8'h44, 1'b1);
    wait_drain("single_word_drain");
    check("req_len_4", last_len, 4);
    check("single_err", err, 0);

    // Partial frame, then a one-byte frame must start at lane 0.
    key_in = 8'h00;
    exp_q.push_back({1'b1, 32'h0000_BBAA});
    exp_q.push_back({1'b1, 32'h0000_005A});
    push_byte(8'hAA, 1'b0);
    push_byte(8'hBB, 1'b1);
    push_byte(8'h5A, 1'b1);
    wait_drain("partial_drain");

    // Timeout: the decryptor never answers the first byte.
    stub_dead = 1'b1;
    exp_q.push_back({1'b1, 32'h0000_6600});
    push_byte(8'h77, 1'b0);
    guard = 0;
    while (!err && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("tmo_err",   err,       1);
    check("tmo_start", dec_start, 0);
    check("tmo_state", dbg_state, S_REL);
    @(posedge clk); #1;
    check("tmo_len_16", last_len, 16);
    stub_dead = 1'b0;
    push_byte(8'h66, 1'b1);
    wait_drain("tmo_drain");
    check("tmo_err_sticky", err, 1);
    check("tmo_next_len", last_len, 4);

    // Back-pressure: 12 bytes with m_ready low, then release.
    m_ready = 1'b0;
    key_in  = 8'hF0;
    exp_q.push_back({1'b0, 32'hF3F2_F1F0});
    exp_q.push_back({1'b0, 32'hF7F6_F5F4});
    exp_q.push_back({1'b1, 32'hFBFA_F9F8});
    fork
      begin
        for (int i = 0; i < 12; i++) push_byte(8'(i), (i == 11));
      end
      begin
        int g = 0;
        @(negedge clk);
        while (!(dbg_state == S_FLUSH && m_valid && !s_ready) && g < 500) begin
          @(negedge clk);
          g++;
        end
        repeat (10) @(negedge clk);
        check("bp_s_ready", s_ready,   0);
        check("bp_m_valid", m_valid,   1);
        check("bp_m_data",  m_data,    32'hF3F2_F1F0);
        check("bp_state",   dbg_state, S_FLUSH);
        @(posedge clk); #1;
        m_ready = 1'b1;
      end
    join
    wait_drain("bp_drain");
    check("bp_s_ready_after", s_ready, 1);

    // Reset while in REQ with two bytes queued.
    key_in = 8'h00;
    push_byte(8'h01, 1'b0);
    push_byte(8'h02, 1'b0);
    push_byte(8'h03, 1'b0);
    check("pre_rst_state", dbg_state, S_REQ);
    rst_n = 1'b0;
    #1;
    check("mid_rst_start",  dec_start,  0);
    check("mid_rst_s_rdy",  s_ready,    1);
    check("mid_rst_cipher", dec_cipher, 0);
    check("mid_rst_m_val",  m_valid,    0);
    check("mid_rst_err",    err,        0);
    check("mid_rst_state",  dbg_state,  S_IDLE);
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses_before = pulses;
    cycles(20);
    check("post_rst_no_req", pulses, pulses_before);
    check("post_rst_start",  dec_start, 0);
    check("post_rst_m_val",  m_valid,   0);
    check("post_rst_state",  dbg_state, S_IDLE);

    // Normal word after reset.
    key_in = 8'hFF;
    exp_q.push_back({1'b1, 32'hFCFD_FEFF});
    push_byte(8'h00, 1'b0);
    push_byte(8'h01, 1'b0);
    push_byte(8'h02, 1'b0);
    push_byte(8'h03, 1'b1);
    wait_drain("post_rst_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_decrypt_sequencer.md
# bnn_decrypt_sequencer

Front-end sequencer for the secure BNN accelerator's decryption path. It buffers an incoming cipher-byte stream in a small FIFO and drives the byte-wide decryptor one byte at a time over its start/done handshake. It packs the returned plaintext bytes into WORD_BYTES-wide binary weight words and presents them to the weight loader on a valid/ready interface.

## Interface
- FIFO_DEPTH, 4, input byte FIFO depth; power of 2, ≥2
- WORD_BYTES, 4, plaintext bytes per output word
- TIMEOUT, 16, cycles allowed in REQ for dec_done to rise
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  cipher byte valid
- s_ready  out  1  FIFO not full
- s_data  in  8  cipher byte
- s_last  in  1  final byte of frame
- key_in  in  8  symmetric key, sampled at each pop
- dec_start  out  1  decryptor start request
- dec_cipher  out  8  byte to decrypt
- dec_key  out  8  key for the current byte
- dec_plain  in  8  decryptor result
- dec_done  in  1  decryptor done level
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accepts word
- m_data  out  8*WORD_BYTES  packed plaintext; byte 0 in bits [7:0]
- m_last  out  1  word closes a frame
- err  out  1  sticky decryptor timeout flag

## Operation
- FIFO: {s_last, s_data} are pushed when s_valid && s_ready, with s_ready = !full. The FIFO is popped only by the FSM in IDLE. A push and a pop in the same cycle are legal. Pointers wrap modulo FIFO_DEPTH, with one extra bit used to detect full/empty.
- FSM states are IDLE, REQ, REL and FLUSH.
- IDLE: if the FIFO is not empty, pop the head into dec_cipher and the cur_last register, latch key_in into dec_key, set dec_start=1 and go to REQ.
- REQ: hold dec_start=1 and count cycles.
  - If dec_done=1, write dec_plain into lane byte_idx of the pack register, set dec_start=0 and go to REL.
  - If the count reaches TIMEOUT first, write 0x00 into the lane, set err=1, set dec_start=0 and go to REL.
- REL: hold dec_start=0 until dec_done=0.
  - If byte_idx==WORD_BYTES-1 or cur_last=1, go to FLUSH.
  - Otherwise increment byte_idx and go to IDLE.
- FLUSH: when m_valid=0 or m_ready=1:
  - load m_data from the pack register; unfilled lanes are 0x00 (partial last word);
  - set m_last=cur_last and m_valid=1;
  - clear the pack register and byte_idx to 0;
  - go to IDLE.
- Output hold: m_valid stays high and m_data/m_last stay stable until m_valid && m_ready. On acceptance without a simultaneous reload, m_valid drops.
- The FIFO keeps accepting input during every state while not full.
- err is cleared only by reset.
- dec_cipher and dec_key hold their values from IDLE pop until the next pop.

## Timing
- Reset values (asynchronous, rst_n=0):
  - s_ready=1 (FIFO empty), dec_start=0, dec_cipher=0, dec_key=0;
  - m_valid=0, m_data=0, m_last=0, err=0;
  - state=IDLE, byte_idx=0, timeout counter=0.
- Reset asserted mid-frame discards FIFO contents, the partial word and any pending output. dec_start drops immediately.
- Push-to-request: a byte pushed into an empty FIFO at edge N is popped at edge N+1, so dec_start is high after edge N+1.
- With the team decryptor (done rises 3 edges after start is sampled high, falls 1 edge after start is sampled low):
  - REQ lasts 4 cycles and REL lasts 2 cycles;
  - the next pop occurs 7 cycles after the previous one.
- Word completion: FLUSH adds 1 cycle when the output register is free. FLUSH stalls while m_valid && !m_ready.
- dec_done already high on entry to REQ is taken as done on the first REQ cycle. dec_done glitching high in IDLE or FLUSH is ignored.
- The timeout counter resets on every REQ entry. A timeout fires on the TIMEOUT-th REQ cycle with dec_done still low.

## Test plan
- Bench decryptor stub: plain = cipher ^ key, done 3 cycles after start.
- Single word: key_in=0x3C, bytes 0x11,0x22,0x33,0x44 (last on 0x44) -> one beat m_data=0x78_0F_1E_2D, m_last=1, err=0.
- Partial frame: bytes 0xAA,0xBB with s_last on 0xBB, key 0x00 -> m_data=0x0000_BBAA, m_last=1. The next frame starts at lane 0.
- Back-pressure: 12 bytes pushed back-to-back with m_ready=0 -> s_ready falls after FIFO_DEPTH bytes remain unconsumed, m_valid held with m_data stable. Releasing m_ready gives 3 words in order with no loss or duplication.
- Timeout: stub never raises done -> after 16 REQ cycles the lane is 0x00, err=1 and stays 1, dec_start drops, and processing continues with the next byte.
- Reset mid-operation: rst_n low while in REQ with 2 bytes queued -> all outputs at reset values within the same cycle. After release, no stale word is emitted and the FIFO is empty.
- Handshake check: assert dec_start never rises while dec_done=1, and dec_cipher/dec_key are stable for the whole REQ+REL window.
